stream_rr_arbiter: RTL and testbench

- Shares one nbits-wide output stream among nports val/rdy input streams using round-robin arbitration.
- Input messages arrive on a flattened port array: port i occupies in_msg[i*nbits +: nbits].
- One registered output stage holds the granted message and its source index.
- Sits in front of any single shared consumer, such as a pass-through or a downstream unit, that accepts one message per cycle.

---
 rtl/stream_rr_arbiter_if.sv | 25 ++
 rtl/stream_rr_arbiter.sv | 84 ++++++++
 tb/tb_stream_rr_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/stream_rr_arbiter_if.sv
// Stream bundle between requesters, the round-robin arbiter and its consumer.
// The slave modport is the arbiter's view; master is the environment's view.
interface stream_rr_arbiter_if #(
   parameter int nports = 2,
   parameter int nbits  = 32,
   parameter int sbits  = (nports > 1) ? $clog2(nports) : 1
);
   logic [nports*nbits-1:0] in_msg;
   logic [nports-1:0]       in_val;
   logic [nports-1:0]       in_rdy;
   logic [nbits-1:0]        out_msg;
   logic [sbits-1:0]        out_src;
   logic                    out_val;
   logic                    out_rdy;

   modport slave (
      input  in_msg, in_val, out_rdy,
      output in_rdy, out_msg, out_src, out_val
   );

   modport master (
      output in_msg, in_val, out_rdy,
      input  in_rdy, out_msg, out_src, out_val
   );
endinterface

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered output stream among nports
// val/rdy requesters. The winner is latched with its source index; the
// priority pointer advances past the winner only on an accepted transfer.
module stream_rr_arbiter #(
   parameter int nports = 2,
   parameter int nbits  = 32,
   parameter int sbits  = (nports > 1) ? $clog2(nports) : 1
) (
   input logic                clk,
   input logic                reset_n,
   stream_rr_arbiter_if.slave bus
);
   logic [sbits-1:0]  ptr_q, ptr_d;
   logic [nbits-1:0]  out_msg_q, out_msg_d;
   logic [sbits-1:0]  out_src_q, out_src_d;
   logic              out_val_q, out_val_d;
   logic              space;
   logic              found;
   logic              xfer;
   logic [sbits-1:0]  gnt;
   logic [sbits-1:0]  idx;
   logic [nports-1:0] rdy;

   // Output register can take a new message if empty or draining this cycle.
   assign space = !out_val_q || bus.out_rdy;

   // Walk ports ptr, ptr+1, ... with wrap; the first valid one wins.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = ptr_q;
      for (int k = 0; k < nports; k++) begin
         if (!found && bus.in_val[idx]) begin
            found = 1'b1;
            gnt   = idx;
         end
         idx = (idx == sbits'(nports - 1)) ? '0 : idx + 1'b1;
      end
   end

   // Ready goes only to the winner, and never while reset is asserted.
   always_comb begin
      rdy = '0;
      if (reset_n && found) rdy[gnt] = space;
   end

   assign xfer = reset_n && found && space;

   // Next state: load the winner, else drain, else hold.
   always_comb begin
      ptr_d     = ptr_q;
      out_msg_d = out_msg_q;
      out_src_d = out_src_q;
      out_val_d = out_val_q;
      if (xfer) begin
         out_msg_d = bus.in_msg[int'(gnt)*nbits +: nbits];
         out_src_d = gnt;
         out_val_d = 1'b1;
         ptr_d     = (gnt == sbits'(nports - 1)) ? '0 : gnt + 1'b1;
      end else if (out_val_q && bus.out_rdy) begin
         out_val_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ptr_q     <= '0;
         out_msg_q <= '0;
         out_src_q <= '0;
         out_val_q <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         out_msg_q <= out_msg_d;
         out_src_q <= out_src_d;
         out_val_q <= out_val_d;
      end
   end

   assign bus.in_rdy  = rdy;
   assign bus.out_msg = out_msg_q;
   assign bus.out_src = out_src_q;
   assign bus.out_val = out_val_q;
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: three instances (2, 4 and 1 ports)
// sharing one clock and reset. Inputs change on the falling edge; outputs
// are sampled on the falling edge or 1 time unit after it.
module tb_stream_rr_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.nports(2), .nbits(32)) if2 ();
   stream_rr_arbiter_if #(.nports(4), .nbits(32)) if4 ();
   stream_rr_arbiter_if #(.nports(1), .nbits(32)) if1 ();

   stream_rr_arbiter #(.nports(2), .nbits(32)) dut2 (.clk(clk), .reset_n(rst_n), .bus(if2));
   stream_rr_arbiter #(.nports(4), .nbits(32)) dut4 (.clk(clk), .reset_n(rst_n), .bus(if4));
   stream_rr_arbiter #(.nports(1), .nbits(32)) dut1 (.clk(clk), .reset_n(rst_n), .bus(if1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      int tx, rx, cyc;
      logic acc, drn;

      rst_n = 1'b0;
      if2.in_msg = '0; if2.in_val = '0; if2.out_rdy = 1'b0;
      if4.in_msg = '0; if4.in_val = '0; if4.out_rdy = 1'b1;
      if1.in_msg = '0; if1.in_val = '0; if1.out_rdy = 1'b1;
      repeat (2) @(negedge clk);

      // Power-up reset state of all three instances
      chk("rst_val2", if2.out_val, 0);
      chk("rst_msg2", if2.out_msg, 0);
      chk("rst_src2", if2.out_src, 0);
      chk("rst_val4", if4.out_val, 0);
      chk("rst_msg4", if4.out_msg, 0);
      chk("rst_val1", if1.out_val, 0);
      rst_n = 1'b1;

      // Reset mid-stream on the 2-port instance
      if2.in_msg = {32'h0, 32'hDEAD0001};
      if2.in_val = 2'b01;
      if2.out_rdy = 1'b0;
      #1 chk("t1_rdy_load", if2.in_rdy, 2'b01);
      @(negedge clk);
      if2.in_val = 2'b00;
      chk("t1_val_held", if2.out_val, 1);
      chk("t1_msg_held", if2.out_msg, 32'hDEAD0001);
      // ptr is now 1; reset must return it to 0
      if2.in_msg = {32'hA1, 32'hA0};
      if2.in_val = 2'b11;
      if2.out_rdy = 1'b1;
      rst_n = 1'b0;
      #1 chk("t1_rdy_in_rst", if2.in_rdy, 2'b00);
      @(negedge clk);
      chk("t1_val_rst", if2.out_val, 0);
      chk("t1_msg_rst", if2.out_msg, 0);
      chk("t1_src_rst", if2.out_src, 0);
      rst_n = 1'b1;
      #1 chk("t1_rdy_post", if2.in_rdy, 2'b01);
      @(negedge clk);
      chk("t1_src_g0", if2.out_src, 0);
      chk("t1_msg_g0", if2.out_msg, 32'hA0);
      chk("t1_val_g0", if2.out_val, 1);
      if2.in_val = 2'b10;
      #1 chk("t1_rdy_p1", if2.in_rdy, 2'b10);
      @(negedge clk);
      chk("t1_src_g1", if2.out_src, 1);
      chk("t1_msg_g1", if2.out_msg, 32'hA1);
      if2.in_val = 2'b00;
      @(negedge clk);
      chk("t1_drained", if2.out_val, 0);

      // Round-robin under full load on the 4-port instance
      if4.in_msg = {32'h103, 32'h102, 32'h101, 32'h100};
      if4.in_val = 4'hF;
      for (int i = 0; i < 8; i++) begin
         #1 chk("t2_rdy", if4.in_rdy, 4'b0001 << (i % 4));
         @(negedge clk);
         chk("t2_src", if4.out_src, i % 4);
         chk("t2_msg", if4.out_msg, 32'h100 + (i % 4));
         chk("t2_val", if4.out_val, 1);
      end
      if4.in_val = 4'h0;
      @(negedge clk);
      chk("t2_drained", if4.out_val, 0);

      // Backpressure on the 2-port instance, then drain+accept at one edge
      if2.in_msg = {32'hCAFE, 32'h0};
      if2.in_val = 2'b10;
      if2.out_rdy = 1'b0;
      #1 chk("t3_rdy_load", if2.in_rdy, 2'b10);
      @(negedge clk);
      if2.in_msg = {32'hBEEF, 32'h0};
      for (int i = 0; i < 3; i++) begin
         #1 chk("t3_rdy_bp", if2.in_rdy, 2'b00);
         chk("t3_val_bp", if2.out_val, 1);
         chk("t3_msg_bp", if2.out_msg, 32'hCAFE);
         chk("t3_src_bp", if2.out_src, 1);
         @(negedge clk);
      end
      if2.out_rdy = 1'b1;
      #1 chk("t3_rdy_release", if2.in_rdy, 2'b10);
      @(negedge clk);
      chk("t3_val_swap", if2.out_val, 1);
      chk("t3_msg_swap", if2.out_msg, 32'hBEEF);
      chk("t3_src_swap", if2.out_src, 1);
      if2.in_val = 2'b00;
      @(negedge clk);
      chk("t3_drained", if2.out_val, 0);

      // Pointer holds across idle cycles (4 ports)
      if4.in_msg = {32'h303, 32'h202, 32'h0, 32'h300};
      if4.in_val = 4'b0100;
      @(negedge clk);
      chk("t4_src_g2", if4.out_src, 2);
      if4.in_val = 4'b0000;
      for (int i = 0; i < 5; i++) begin
         #1 chk("t4_rdy_idle", if4.in_rdy, 4'b0000);
         @(negedge clk);
      end
      if4.in_val = 4'b1001;
      #1 chk("t4_rdy_p3", if4.in_rdy, 4'b1000);
      @(negedge clk);
      chk("t4_src_g3", if4.out_src, 3);
      chk("t4_msg_g3", if4.out_msg, 32'h303);
      if4.in_val = 4'b0001;
      #1 chk("t4_rdy_p0", if4.in_rdy, 4'b0001);
      @(negedge clk);
      chk("t4_src_g0", if4.out_src, 0);
      chk("t4_msg_g0", if4.out_msg, 32'h300);

      // Wrap-around with sparse requests: reach ptr=3 via a grant to port 2
      if4.in_msg = {32'h403, 32'h402, 32'h401, 32'h400};
      if4.in_val = 4'b0100;
      @(negedge clk);
      chk("t5_src_g2", if4.out_src, 2);
      if4.in_val = 4'b1010;
      #1 chk("t5_rdy_p3", if4.in_rdy, 4'b1000);
      @(negedge clk);
      chk("t5_src_g3", if4.out_src, 3);
      if4.in_val = 4'b0010;
      #1 chk("t5_rdy_p1", if4.in_rdy, 4'b0010);
      @(negedge clk);
      chk("t5_src_g1", if4.out_src, 1);
      chk("t5_msg_g1", if4.out_msg, 32'h401);
      // ptr should be 2: port 3 beats port 0
      if4.in_val = 4'b1001;
      #1 chk("t5_rdy_ptr2", if4.in_rdy, 4'b1000);
      @(negedge clk);
      chk("t5_src_g3b", if4.out_src, 3);
      if4.in_val = 4'b0001;
      @(negedge clk);
      chk("t5_src_g0", if4.out_src, 0);
      if4.in_val = 4'b0000;
      @(negedge clk);

      // Single-port throughput with toggling out_rdy
      tx = 0; rx = 0; cyc = 0;
      while (rx < 10 && cyc < 100) begin
         if1.out_rdy = (cyc % 2) == 0;
         if1.in_val  = (tx < 10);
         if1.in_msg  = 32'(tx);
         #1;
         acc = if1.in_val[0] && if1.in_rdy[0];
         drn = if1.out_val && if1.out_rdy;
         if (drn) begin
            chk("t6_msg", if1.out_msg, 32'(rx));
            chk("t6_src", if1.out_src, 0);
            rx++;
         end
         @(negedge clk);
         if (acc) tx++;
         cyc++;
      end
      chk("t6_count", 64'(rx), 10);
      if1.in_val = 1'b0;
      #1 chk("t6_empty", if1.out_val, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
